bcd_down_counter: RTL and testbench

//   Loadable multi-digit BCD countdown timer; mirror of the team's BCD up counter.

---
 rtl/bcd_down_counter.sv | 140 ++++++++++++++
 tb/tb_bcd_down_counter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable multi-digit BCD countdown timer with start,
// pause (en), prescaler and a one-cycle done pulse on reaching zero.
// Optional feature macro: AUTO_RELOAD_EN. When it is defined, reaching zero
// reloads the last loaded preset and keeps running instead of stopping.
module bcd_down_counter #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  busy,
    output logic                  expired,
    output logic                  done
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned PW = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  ONE     = W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   pre, pre_n;
    logic [W-1:0]    cnt_n;
    logic            done_n;
`ifdef AUTO_RELOAD_EN
    logic [W-1:0]    reload, reload_n;
`endif

    // Clamp every nibble above 9 down to 9 so the count is always valid BCD.
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    // Ripple-borrow BCD decrement: a digit borrows only while all lower digits were 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // State, count, prescaler and done pulse registers; reset clears all at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            pre    <= '0;
            done   <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pre    <= pre_n;
            done   <= done_n;
`ifdef AUTO_RELOAD_EN
            reload <= reload_n;
`endif
        end
    end

    // Next-state logic with priority load > start > count.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pre_n    = pre;
        done_n   = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_n = reload;
`endif
        if (load) begin
            cnt_n    = clamp_bcd(load_val);
`ifdef AUTO_RELOAD_EN
            reload_n = clamp_bcd(load_val);
`endif
            pre_n    = '0;
            state_n  = IDLE;
        end else if (start && state == IDLE) begin
            if (cnt != '0) begin
                state_n = RUN;
            end else begin
                state_n = DONE;
                done_n  = 1'b1;
            end
        end else if (state == RUN && en) begin
            if (pre == PRE_MAX) begin
                pre_n = '0;
                if (cnt == ONE) begin
                    done_n = 1'b1;
`ifdef AUTO_RELOAD_EN
                    if (reload != '0) begin
                        cnt_n = reload;
                    end else begin
                        cnt_n   = '0;
                        state_n = DONE;
                    end
`else
                    cnt_n   = '0;
                    state_n = DONE;
`endif
                end else begin
                    cnt_n = bcd_dec(cnt);
                end
            end else begin
                pre_n = pre + 1'b1;
            end
        end
    end

    // Status flags decode directly from the state register.
    always_comb begin
        busy    = (state == RUN);
        expired = (state == DONE);
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: directed and randomized checks of bcd_down_counter
// against a decimal-arithmetic reference model, for TICK_DIV=1 and TICK_DIV=4.
module tb_bcd_down_counter;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst, load, start, en;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt1, cnt4;
    logic         busy1, busy4, exp1, exp4, done1, done4;

    int checks = 0;
    int passes = 0;

    // Model state per instance: 0 idle, 1 run, 2 done; count kept as a decimal integer.
    int td[2] = '{1, 4};
    int mst[2], mcnt[2], mpre[2], mrel[2];
    bit mdone[2];

    bcd_down_counter #(.DIGITS(DIGITS), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .en(en),
        .cnt(cnt1), .busy(busy1), .expired(exp1), .done(done1)
    );

    bcd_down_counter #(.DIGITS(DIGITS), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .en(en),
        .cnt(cnt4), .busy(busy4), .expired(exp4), .done(done4)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [W-1:0] v);
        int s, p, d;
        s = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            s = s + d * p;
            p = p * 10;
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mst[k] = 0; mcnt[k] = 0; mpre[k] = 0; mrel[k] = 0; mdone[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            mdone[k] = 1'b0;
            if (load) begin
                mcnt[k] = clamp_val(load_val);
                mrel[k] = mcnt[k];
                mpre[k] = 0;
                mst[k]  = 0;
            end else if (start && mst[k] == 0) begin
                if (mcnt[k] != 0) mst[k] = 1;
                else begin mst[k] = 2; mdone[k] = 1'b1; end
            end else if (mst[k] == 1 && en) begin
                if (mpre[k] == td[k] - 1) begin
                    mpre[k] = 0;
                    mcnt[k] = mcnt[k] - 1;
                    if (mcnt[k] == 0) begin
                        mdone[k] = 1'b1;
`ifdef AUTO_RELOAD_EN
                        if (mrel[k] != 0) mcnt[k] = mrel[k];
                        else mst[k] = 2;
`else
                        mst[k] = 2;
`endif
                    end
                end else begin
                    mpre[k] = mpre[k] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cnt1",     32'(cnt1),  32'(to_bcd(mcnt[0])));
        chk("busy1",    32'(busy1), 32'(mst[0] == 1));
        chk("expired1", 32'(exp1),  32'(mst[0] == 2));
        chk("done1",    32'(done1), 32'(mdone[0]));
        chk("cnt4",     32'(cnt4),  32'(to_bcd(mcnt[1])));
        chk("busy4",    32'(busy4), 32'(mst[1] == 1));
        chk("expired4", 32'(exp4),  32'(mst[1] == 2));
        chk("done4",    32'(done4), 32'(mdone[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; en = 1'b0; load_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Count 25 down to 00 with borrow through 20 -> 19.
        load = 1'b1; load_val = 8'h25; tick();
        load = 1'b0; start = 1'b1; en = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 5) chk("borrow19", 32'(cnt1), 32'h19);
        end
`ifdef AUTO_RELOAD_EN
        chk("t1_cnt", 32'(cnt1), 32'h25);
        chk("t1_busy", 32'(busy1), 32'd1);
`else
        chk("t1_cnt", 32'(cnt1), 32'h00);
        chk("t1_exp", 32'(exp1), 32'd1);
        chk("t1_busy", 32'(busy1), 32'd0);
`endif
        chk("t1_done", 32'(done1), 32'd1);
        tick();
        chk("t1_done_off", 32'(done1), 32'd0);

        // Nibble clamp, then start from zero.
        load = 1'b1; load_val = 8'hAF; tick();
        chk("clamp", 32'(cnt1), 32'h99);
        load_val = 8'h00; tick();
        load = 1'b0; start = 1'b1; tick();
        start = 1'b0;
        chk("zero_done", 32'(done1), 32'd1);
        chk("zero_exp", 32'(exp1), 32'd1);
        tick();

        // Pause holds count and prescaler.
        load = 1'b1; load_val = 8'h10; tick();
        load = 1'b0; start = 1'b1; en = 1'b1; tick();
        start = 1'b0;
        repeat (3) tick();
        en = 1'b0;
        repeat (5) tick();
        chk("pause", 32'(cnt1), 32'h07);
        en = 1'b1; tick();
        chk("resume", 32'(cnt1), 32'h06);

        // Prescaler of 4 on the second instance.
        load = 1'b1; load_val = 8'h03; tick();
        load = 1'b0; start = 1'b1; tick();
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 4)  chk("div4_e4",  32'(cnt4), 32'h02);
            if (i == 11) chk("div4_e11", 32'(cnt4), 32'h01);
        end
`ifdef AUTO_RELOAD_EN
        chk("div4_e12", 32'(cnt4), 32'h03);
`else
        chk("div4_e12", 32'(cnt4), 32'h00);
`endif
        chk("div4_done", 32'(done4), 32'd1);

        // Load wins over start in the same cycle; asynchronous reset mid-run.
        load = 1'b1; start = 1'b1; load_val = 8'h42; tick();
        chk("ld_st_busy", 32'(busy1), 32'd0);
        chk("ld_st_cnt", 32'(cnt1), 32'h42);
        load = 1'b0; tick();
        start = 1'b0; repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_cnt", 32'(cnt1), 32'h00);
        #1 rst = 1'b0;
        tick();

`ifdef AUTO_RELOAD_EN
        // Periodic reload from 02.
        load = 1'b1; load_val = 8'h02; tick();
        load = 1'b0; start = 1'b1; en = 1'b1; tick();
        start = 1'b0;
        tick();
        chk("ar_01", 32'(cnt1), 32'h01);
        tick();
        chk("ar_reload", 32'(cnt1), 32'h02);
        chk("ar_done", 32'(done1), 32'd1);
        chk("ar_busy", 32'(busy1), 32'd1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            load  = ($urandom_range(15) == 0);
            start = ($urandom_range(3) == 0);
            en    = start ? 1'b1 : ($urandom_range(3) != 0);
            if ($urandom_range(1) == 1) load_val = W'($urandom_range(9));
            else load_val = W'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
